// File: rtl/l_line_io_buffer_pkg.sv
// Shared helpers for the buffered line I/O block.
// Width functions and the data-bus reset value.
package l_io_pkg;

   function automatic int ch_w(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam logic DATA_RST = 1'b0;

endpackage

// File: rtl/l_line_io_buffer_if.sv
// Core-side and device-side signals of the line I/O buffer.
// master drives requests and device inputs; slave is the buffer.
interface l_line_io_buffer_if
   import l_io_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int CHANNELS = 2
);
   localparam int CH_W = ch_w(CHANNELS);

   logic                         coreWrite;
   logic                         coreRead;
   logic [CH_W-1:0]              coreChannel;
   logic [DATA_W-1:0]            coreData;
   logic [DATA_W-1:0]            coreInput;
   logic                         coreStall;
   logic [CHANNELS*DATA_W-1:0]   txData;
   logic [CHANNELS-1:0]          txValid;
   logic [CHANNELS-1:0]          txReady;
   logic [CHANNELS*DATA_W-1:0]   rxData;
   logic [CHANNELS-1:0]          rxValid;
   logic [CHANNELS-1:0]          rxReady;
   logic [CHANNELS-1:0]          txEmpty;

   modport master (
      output coreWrite, coreRead, coreChannel, coreData,
      output txReady, rxData, rxValid,
      input  coreInput, coreStall, txData, txValid,
      input  rxReady, txEmpty
   );

   modport slave (
      input  coreWrite, coreRead, coreChannel, coreData,
      input  txReady, rxData, rxValid,
      output coreInput, coreStall, txData, txValid,
      output rxReady, txEmpty
   );

endinterface

// File: rtl/l_line_io_buffer_fifo.sv
// Single-clock FIFO with wrap-around pointers and an occupancy count.
// head reads 0 while empty so callers need no extra gating.
module l_line_fifo
   import l_io_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic [DATA_W-1:0]         data,
   output logic [DATA_W-1:0]         head,
   output logic                      full,
   output logic                      empty,
   output logic [cnt_w(DEPTH)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? {DATA_W{DATA_RST}} : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (do_pop && !do_push)
            count <= count - CW'(1);
      end
   end

   // Storage needs no reset: head is masked by empty.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= data;
   end

endmodule

// File: rtl/l_line_io_buffer.sv
// Buffered multi-channel replacement for the sector's output/input line.
// Holds channel decode, stall logic and data muxing around 2*CHANNELS FIFOs.
module l_line_io_buffer
   import l_io_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   l_line_io_buffer_if.slave   bus
);
   localparam int CH_W = ch_w(CHANNELS);
   localparam int CW   = cnt_w(DEPTH);

   logic              live;
   logic [CHANNELS-1:0] sel;
   logic [CHANNELS-1:0] tx_full;
   logic [CHANNELS-1:0] tx_empty;
   logic [CHANNELS-1:0] rx_full;
   logic [CHANNELS-1:0] rx_empty;
   logic [CHANNELS-1:0] tx_push;
   logic [CHANNELS-1:0] tx_pop;
   logic [CHANNELS-1:0] rx_push;
   logic [CHANNELS-1:0] rx_pop;
   logic [DATA_W-1:0] tx_head [CHANNELS];
   logic [DATA_W-1:0] rx_head [CHANNELS];
   logic [CW-1:0]     tx_cnt  [CHANNELS];
   logic [CW-1:0]     rx_cnt  [CHANNELS];
   logic              sel_tx_full;
   logic              sel_rx_empty;
   logic [DATA_W-1:0] sel_rx_head;
   logic              stall;

   // Core side stays inert until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         live <= 1'b0;
      else
         live <= 1'b1;
   end

   // Out-of-range channels match nothing, so they never stall.
   always_comb begin
      sel          = '0;
      sel_tx_full  = 1'b0;
      sel_rx_empty = 1'b0;
      sel_rx_head  = {DATA_W{DATA_RST}};
      for (int k = 0; k < CHANNELS; k++) begin
         if (bus.coreChannel == CH_W'(k)) begin
            sel[k]       = 1'b1;
            sel_tx_full  = tx_full[k];
            sel_rx_empty = rx_empty[k];
            if (rx_cnt[k] != '0)
               sel_rx_head = rx_head[k];
         end
      end
   end

   assign stall = live &&
                  ((bus.coreWrite && sel_tx_full) ||
                   (bus.coreRead && sel_rx_empty));

   assign bus.coreStall = stall;
   assign bus.coreInput = live ? sel_rx_head
                               : {DATA_W{DATA_RST}};

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign tx_push[k] = live && bus.coreWrite && !stall && sel[k];
      assign rx_pop[k]  = live && bus.coreRead && !stall && sel[k];
      assign tx_pop[k]  = !tx_empty[k] && bus.txReady[k];
      assign rx_push[k] = bus.rxValid[k] && bus.rxReady[k];

      assign bus.txValid[k] = !tx_empty[k];
      assign bus.txEmpty[k] = (tx_cnt[k] == '0);
      assign bus.rxReady[k] = live && !rx_full[k];
      assign bus.txData[k*DATA_W +: DATA_W] = tx_head[k];

      l_line_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_tx (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (tx_push[k]),
         .pop   (tx_pop[k]),
         .data  (bus.coreData),
         .head  (tx_head[k]),
         .full  (tx_full[k]),
         .empty (tx_empty[k]),
         .count (tx_cnt[k])
      );

      l_line_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_rx (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (rx_push[k]),
         .pop   (rx_pop[k]),
         .data  (bus.rxData[k*DATA_W +: DATA_W]),
         .head  (rx_head[k]),
         .full  (rx_full[k]),
         .empty (rx_empty[k]),
         .count (rx_cnt[k])
      );
   end

endmodule

// File: tb/tb_l_line_io_buffer.sv
// Scenario bench for l_line_io_buffer with a queue-based reference model.
// Three channels so that channel index 3 is out of range.
module tb_l_line_io_buffer;
   localparam int DW = 16;
   localparam int NC = 3;
   localparam int DP = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [DW-1:0] txq [NC][$];
   logic [DW-1:0] rxq [NC][$];
   bit            m_live;

   l_line_io_buffer_if #(.DATA_W(DW), .CHANNELS(NC)) bus ();

   l_line_io_buffer #(
      .DATA_W   (DW),
      .CHANNELS (NC),
      .DEPTH    (DP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock, applying the queue model to the current inputs.
   task automatic tick();
      int c;
      bit st;
      bit txp [NC];
      bit rxp [NC];
      c  = int'(bus.coreChannel);
      st = 1'b0;
      if (m_live && c < NC)
         st = (bus.coreWrite && txq[c].size() == DP) ||
              (bus.coreRead && rxq[c].size() == 0);
      for (int k = 0; k < NC; k++) begin
         txp[k] = (txq[k].size() > 0) && bus.txReady[k];
         rxp[k] = m_live && (rxq[k].size() < DP) && bus.rxValid[k];
      end
      for (int k = 0; k < NC; k++) begin
         if (txp[k]) void'(txq[k].pop_front());
         if (rxp[k]) rxq[k].push_back(bus.rxData[k*DW +: DW]);
      end
      if (m_live && !st && c < NC) begin
         if (bus.coreWrite) txq[c].push_back(bus.coreData);
         if (bus.coreRead) void'(rxq[c].pop_front());
      end
      @(posedge clk);
      m_live = rst_n;
      #1;
   endtask

   task automatic clear_model();
      for (int k = 0; k < NC; k++) begin
         txq[k].delete();
         rxq[k].delete();
      end
      m_live = 1'b0;
   endtask

   task automatic test_reset();
      rst_n           = 1'b0;
      bus.coreWrite   = 1'b1;
      bus.coreRead    = 1'b1;
      bus.coreChannel = '0;
      bus.coreData    = 16'h1234;
      bus.txReady     = '0;
      bus.rxValid     = '1;
      bus.rxData      = '1;
      clear_model();
      #1;
      checks++; if (bus.txValid !== 3'b000) begin errors++; $display("FAIL rst_txValid got %b exp 000", bus.txValid); end
      checks++; if (bus.txEmpty !== 3'b111) begin errors++; $display("FAIL rst_txEmpty got %b exp 111", bus.txEmpty); end
      checks++; if (bus.rxReady !== 3'b000) begin errors++; $display("FAIL rst_rxReady got %b exp 000", bus.rxReady); end
      checks++; if (bus.coreStall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.coreStall); end
      checks++; if (bus.coreInput !== 16'h0) begin errors++; $display("FAIL rst_coreInput got %h exp 0000", bus.coreInput); end
      checks++; if (bus.txData !== 48'h0) begin errors++; $display("FAIL rst_txData got %h exp 0", bus.txData); end
      tick();
      tick();
      bus.coreWrite = 1'b0;
      bus.coreRead  = 1'b0;
      bus.rxValid   = '0;
      rst_n = 1'b1;
      #1;
      checks++; if (bus.rxReady !== 3'b000) begin errors++; $display("FAIL rel_rxReady_before_edge got %b exp 000", bus.rxReady); end
      tick();
      checks++; if (bus.rxReady !== 3'b111) begin errors++; $display("FAIL rel_rxReady_after_edge got %b exp 111", bus.rxReady); end
   endtask

   task automatic test_reset_mid();
      bus.coreChannel = 2'd0;
      for (int i = 0; i < 3; i++) begin
         bus.coreWrite = 1'b1;
         bus.coreData  = 16'hC000 + 16'(i);
         tick();
      end
      bus.coreWrite = 1'b0;
      bus.rxValid   = 3'b100;
      bus.rxData    = {16'h7777, 32'h0};
      tick();
      bus.rxValid     = '0;
      bus.coreChannel = 2'd2;
      #1;
      checks++; if (bus.coreInput !== 16'h7777) begin errors++; $display("FAIL mid_pre_coreInput got %h exp 7777", bus.coreInput); end
      checks++; if (bus.txValid !== 3'b001) begin errors++; $display("FAIL mid_pre_txValid got %b exp 001", bus.txValid); end
      rst_n = 1'b0;
      clear_model();
      #1;
      checks++; if (bus.txValid !== 3'b000) begin errors++; $display("FAIL mid_txValid got %b exp 000", bus.txValid); end
      checks++; if (bus.txEmpty !== 3'b111) begin errors++; $display("FAIL mid_txEmpty got %b exp 111", bus.txEmpty); end
      checks++; if (bus.rxReady !== 3'b000) begin errors++; $display("FAIL mid_rxReady got %b exp 000", bus.rxReady); end
      checks++; if (bus.coreInput !== 16'h0) begin errors++; $display("FAIL mid_coreInput got %h exp 0000", bus.coreInput); end
      checks++; if (bus.txData !== 48'h0) begin errors++; $display("FAIL mid_txData got %h exp 0", bus.txData); end
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (bus.txValid !== 3'b000) begin errors++; $display("FAIL mid_after_txValid got %b exp 000", bus.txValid); end
   endtask

   task automatic test_tx_fill_drain();
      bus.txReady     = '0;
      bus.coreRead    = 1'b0;
      bus.coreChannel = 2'd0;
      for (int i = 0; i < 4; i++) begin
         bus.coreWrite = 1'b1;
         bus.coreData  = 16'hA001 + 16'(i);
         #1;
         checks++; if (bus.coreStall !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d got %b exp 0", i, bus.coreStall); end
         tick();
      end
      bus.coreData = 16'hA005;
      #1;
      checks++; if (bus.coreStall !== 1'b1) begin errors++; $display("FAIL fill_5th_stall got %b exp 1", bus.coreStall); end
      tick();
      bus.coreWrite = 1'b0;
      bus.txReady   = 3'b001;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (bus.txData[15:0] !== 16'hA001 + 16'(i)) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, bus.txData[15:0], 16'hA001 + 16'(i)); end
         tick();
      end
      checks++; if (bus.txValid[0] !== 1'b0) begin errors++; $display("FAIL drain_done_txValid got %b exp 0", bus.txValid[0]); end
      bus.txReady = '0;
   endtask

   task automatic test_rx_empty_read();
      bus.coreChannel = 2'd1;
      bus.coreRead    = 1'b1;
      bus.rxValid     = 3'b010;
      bus.rxData      = {16'h0, 16'h5A5A, 16'h0};
      #1;
      checks++; if (bus.coreStall !== 1'b1) begin errors++; $display("FAIL rxe_stall got %b exp 1", bus.coreStall); end
      checks++; if (bus.coreInput !== 16'h0) begin errors++; $display("FAIL rxe_coreInput got %h exp 0000", bus.coreInput); end
      tick();
      bus.rxValid = '0;
      #1;
      checks++; if (bus.coreStall !== 1'b0) begin errors++; $display("FAIL rxe_release got %b exp 0", bus.coreStall); end
      checks++; if (bus.coreInput !== 16'h5A5A) begin errors++; $display("FAIL rxe_data got %h exp 5a5a", bus.coreInput); end
      tick();
      checks++; if (bus.coreStall !== 1'b1) begin errors++; $display("FAIL rxe_popped_stall got %b exp 1", bus.coreStall); end
      bus.coreRead = 1'b0;
   endtask

   task automatic test_combined_stall();
      bus.coreChannel = 2'd0;
      bus.coreWrite   = 1'b1;
      bus.coreRead    = 1'b1;
      bus.coreData    = 16'h1234;
      #1;
      checks++; if (bus.coreStall !== 1'b1) begin errors++; $display("FAIL comb_stall got %b exp 1", bus.coreStall); end
      tick();
      bus.coreWrite = 1'b0;
      bus.coreRead  = 1'b0;
      #1;
      checks++; if (bus.txEmpty[0] !== 1'b1) begin errors++; $display("FAIL comb_tx_unchanged got %b exp 1", bus.txEmpty[0]); end
   endtask

   task automatic test_back_to_back();
      bus.coreChannel = 2'd0;
      bus.txReady     = '0;
      for (int i = 0; i < 2; i++) begin
         bus.coreWrite = 1'b1;
         bus.coreData  = 16'hB000 + 16'(i);
         tick();
      end
      bus.txReady = 3'b001;
      for (int i = 0; i < 10; i++) begin
         bus.coreData = 16'hB002 + 16'(i);
         #1;
         checks++; if (bus.txData[15:0] !== 16'hB000 + 16'(i)) begin errors++; $display("FAIL b2b_head_%0d got %h exp %h", i, bus.txData[15:0], 16'hB000 + 16'(i)); end
         checks++; if (bus.coreStall !== 1'b0) begin errors++; $display("FAIL b2b_stall_%0d got %b exp 0", i, bus.coreStall); end
         tick();
      end
      bus.coreWrite = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (bus.txData[15:0] !== 16'hB00A + 16'(i)) begin errors++; $display("FAIL b2b_tail_%0d got %h exp %h", i, bus.txData[15:0], 16'hB00A + 16'(i)); end
         tick();
      end
      checks++; if (bus.txValid[0] !== 1'b0) begin errors++; $display("FAIL b2b_count got txValid %b exp 0", bus.txValid[0]); end
      bus.txReady = '0;
   endtask

   task automatic test_out_of_range();
      bus.coreChannel = 2'd0;
      bus.rxValid     = 3'b001;
      bus.rxData      = {32'h0, 16'h1111};
      tick();
      bus.rxValid     = '0;
      bus.coreChannel = 2'd3;
      bus.coreWrite   = 1'b1;
      bus.coreData    = 16'hFFFF;
      #1;
      checks++; if (bus.coreStall !== 1'b0) begin errors++; $display("FAIL oor_wr_stall got %b exp 0", bus.coreStall); end
      tick();
      bus.coreWrite = 1'b0;
      bus.coreRead  = 1'b1;
      #1;
      checks++; if (bus.txEmpty !== 3'b111) begin errors++; $display("FAIL oor_txEmpty got %b exp 111", bus.txEmpty); end
      checks++; if (bus.coreInput !== 16'h0) begin errors++; $display("FAIL oor_rd_data got %h exp 0000", bus.coreInput); end
      checks++; if (bus.coreStall !== 1'b0) begin errors++; $display("FAIL oor_rd_stall got %b exp 0", bus.coreStall); end
      tick();
      bus.coreRead    = 1'b0;
      bus.coreChannel = 2'd0;
      #1;
      checks++; if (bus.coreInput !== 16'h1111) begin errors++; $display("FAIL oor_no_pop got %h exp 1111", bus.coreInput); end
      bus.coreRead = 1'b1;
      tick();
      bus.coreRead = 1'b0;
   endtask

   task automatic test_random();
      int            c;
      int            bad;
      logic          e_stall;
      logic [DW-1:0] e_in;
      logic [NC-1:0] e_tv;
      logic [NC-1:0] e_te;
      logic [NC-1:0] e_rr;
      logic [NC*DW-1:0] e_td;
      bad = 0;
      for (int n = 0; n < 400; n++) begin
         bus.coreChannel = 2'($urandom_range(0, 3));
         bus.coreWrite   = ($urandom_range(0, 99) < 55);
         bus.coreRead    = ($urandom_range(0, 99) < 45);
         bus.coreData    = 16'($urandom);
         bus.txReady     = 3'($urandom);
         bus.rxValid     = 3'($urandom);
         bus.rxData      = {16'($urandom), 16'($urandom), 16'($urandom)};
         #1;
         c       = int'(bus.coreChannel);
         e_stall = 1'b0;
         e_in    = '0;
         if (m_live && c < NC) begin
            e_stall = (bus.coreWrite && txq[c].size() == DP) ||
                      (bus.coreRead && rxq[c].size() == 0);
            if (rxq[c].size() > 0) e_in = rxq[c][0];
         end
         for (int k = 0; k < NC; k++) begin
            e_tv[k] = txq[k].size() > 0;
            e_te[k] = txq[k].size() == 0;
            e_rr[k] = m_live && rxq[k].size() < DP;
            e_td[k*DW +: DW] = (txq[k].size() > 0) ? txq[k][0] : 16'h0;
         end
         checks++; if (bus.coreStall !== e_stall) begin errors++; bad++; if (bad < 20) $display("FAIL rnd_stall cyc %0d got %b exp %b", n, bus.coreStall, e_stall); end
         checks++; if (bus.coreInput !== e_in) begin errors++; bad++; if (bad < 20) $display("FAIL rnd_coreInput cyc %0d got %h exp %h", n, bus.coreInput, e_in); end
         checks++; if (bus.txValid !== e_tv) begin errors++; bad++; if (bad < 20) $display("FAIL rnd_txValid cyc %0d got %b exp %b", n, bus.txValid, e_tv); end
         checks++; if (bus.txEmpty !== e_te) begin errors++; bad++; if (bad < 20) $display("FAIL rnd_txEmpty cyc %0d got %b exp %b", n, bus.txEmpty, e_te); end
         checks++; if (bus.rxReady !== e_rr) begin errors++; bad++; if (bad < 20) $display("FAIL rnd_rxReady cyc %0d got %b exp %b", n, bus.rxReady, e_rr); end
         checks++; if (bus.txData !== e_td) begin errors++; bad++; if (bad < 20) $display("FAIL rnd_txData cyc %0d got %h exp %h", n, bus.txData, e_td); end
         tick();
      end
      bus.coreWrite = 1'b0;
      bus.coreRead  = 1'b0;
      bus.txReady   = '0;
      bus.rxValid   = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_reset_mid();
      test_tx_fill_drain();
      test_rx_empty_read();
      test_combined_stall();
      test_back_to_back();
      test_out_of_range();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
